// File: rtl/z80_pkg.sv
// rtl/z80_pkg.sv - shared types and constants for the Z80 ALU sequencer
package z80_pkg;

    // ALU operation codes presented on alu_select.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_IMM   = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_e;

    // 3-bit register index as encoded in the opcode.
    localparam logic [2:0] REG_B      = 3'd0;
    localparam logic [2:0] REG_C      = 3'd1;
    localparam logic [2:0] REG_D      = 3'd2;
    localparam logic [2:0] REG_E      = 3'd3;
    localparam logic [2:0] REG_H      = 3'd4;
    localparam logic [2:0] REG_L      = 3'd5;
    localparam logic [2:0] REG_HL_IND = 3'd6;
    localparam logic [2:0] REG_A      = 3'd7;

    // The ooo field selects ADD/SUB/AND/XOR/OR; ADC, SBC and CP are not handled.
    function automatic logic alu_ooo_valid(input logic [2:0] ooo);
        return (ooo == 3'b000) || (ooo == 3'b010) || (ooo == 3'b100) ||
               (ooo == 3'b101) || (ooo == 3'b110);
    endfunction

    function automatic alu_sel_e alu_ooo_sel(input logic [2:0] ooo);
        case (ooo)
            3'b010:  return ALU_SUB;
            3'b100:  return ALU_AND;
            3'b101:  return ALU_XOR;
            3'b110:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/z80_op_decode.sv
// rtl/z80_op_decode.sv - combinational opcode classifier for the ALU sequencer
// Ports:
//   op          in  8  opcode byte
//   is_alu      out 1  ALU instruction (register or immediate form)
//   is_imm      out 1  instruction needs a second (immediate) byte
//   is_ld       out 1  LD r,n
//   is_nop      out 1  NOP (0x00)
//   is_illegal  out 1  anything not listed above
//   alu_sel     out 4  ALU operation code
//   r           out 3  register index (destination for LD, source for ALU)
module z80_op_decode
    import z80_pkg::*;
(
    input  logic [7:0] op,
    output logic       is_alu,
    output logic       is_imm,
    output logic       is_ld,
    output logic       is_nop,
    output logic       is_illegal,
    output logic [3:0] alu_sel,
    output logic [2:0] r
);

    logic [1:0] x;
    logic [2:0] y;
    logic [2:0] z;
    logic       alu_reg;
    logic       alu_imm;

    assign x = op[7:6];
    assign y = op[5:3];
    assign z = op[2:0];

    always_comb begin
        is_nop     = (op == 8'h00);
        is_ld      = (x == 2'b00) && (z == REG_HL_IND) && (y != REG_HL_IND);
        alu_reg    = (x == 2'b10) && alu_ooo_valid(y) && (z != REG_HL_IND);
        alu_imm    = (x == 2'b11) && alu_ooo_valid(y) && (z == 3'b110);
        is_alu     = alu_reg || alu_imm;
        is_imm     = is_ld || alu_imm;
        is_illegal = !(is_nop || is_ld || is_alu);
        alu_sel    = alu_ooo_sel(y);
        r          = is_ld ? y : z;
    end

endmodule

// File: rtl/z80_alu_sequencer.sv
// rtl/z80_alu_sequencer.sv - feeds an external 8-bit ALU from a Z80 opcode byte stream
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   op_valid/op_data       opcode/immediate byte in; op_ready = byte accepted this cycle
//   alu_select/alu_a/alu_b registered ALU operation and operands
//   alu_result             combinational ALU output, written to A in EXEC
//   acc, zero              accumulator and zero flag of the last ALU result
//   retire, illegal        one-cycle pulses for completed / dropped instructions
module z80_alu_sequencer
    import z80_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       op_valid,
    input  logic [7:0] op_data,
    output logic       op_ready,
    output logic [3:0] alu_select,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    output logic [7:0] acc,
    output logic       zero,
    output logic       retire,
    output logic       illegal
);

    seq_state_e state;
    seq_state_e state_nx;

    logic [7:0] regs [8];
    logic       pend_ld;    // IMM byte is an LD operand rather than an ALU operand
    logic [2:0] pend_r;
    logic       retire_q;
    logic       illegal_q;
    logic       accept;

    logic       d_is_alu;
    logic       d_is_imm;
    logic       d_is_ld;
    logic       d_is_nop;
    logic       d_is_illegal;
    logic [3:0] d_alu_sel;
    logic [2:0] d_r;

    z80_op_decode u_decode (
        .op         (op_data),
        .is_alu     (d_is_alu),
        .is_imm     (d_is_imm),
        .is_ld      (d_is_ld),
        .is_nop     (d_is_nop),
        .is_illegal (d_is_illegal),
        .alu_sel    (d_alu_sel),
        .r          (d_r)
    );

    assign op_ready = reset_n && (state != ST_EXEC);
    assign accept   = op_valid && op_ready;
    assign acc      = regs[REG_A];
    // A reset arriving during the completing cycle aborts the instruction,
    // so the pulses are masked while reset is held.
    assign retire   = retire_q && reset_n;
    assign illegal  = illegal_q && reset_n;

    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH: begin
                if (accept) begin
                    if (d_is_imm) begin
                        state_nx = ST_IMM;
                    end else if (d_is_alu) begin
                        state_nx = ST_EXEC;
                    end
                end
            end
            ST_IMM: begin
                if (accept) begin
                    state_nx = pend_ld ? ST_FETCH : ST_EXEC;
                end
            end
            ST_EXEC: state_nx = ST_FETCH;
            default: state_nx = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_FETCH;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
            pend_ld    <= 1'b0;
            pend_r     <= 3'd0;
            alu_select <= 4'd0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            zero       <= 1'b0;
            retire_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (accept) begin
                        if (d_is_nop) begin
                            retire_q <= 1'b1;
                        end else if (d_is_illegal) begin
                            illegal_q <= 1'b1;
                        end else if (d_is_ld) begin
                            pend_ld <= 1'b1;
                            pend_r  <= d_r;
                        end else begin
                            // A cannot change before EXEC, so it is safe to
                            // latch it now even for the immediate form.
                            pend_ld    <= 1'b0;
                            alu_select <= d_alu_sel;
                            alu_a      <= regs[REG_A];
                            if (!d_is_imm) begin
                                alu_b    <= regs[d_r];
                                retire_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_IMM: begin
                    if (accept) begin
                        retire_q <= 1'b1;
                        if (pend_ld) begin
                            regs[pend_r] <= op_data;
                        end else begin
                            alu_b <= op_data;
                        end
                    end
                end
                ST_EXEC: begin
                    regs[REG_A] <= alu_result;
                    zero        <= (alu_result == 8'h00);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_alu_sequencer.sv
// tb/tb_z80_alu_sequencer.sv - self-checking bench for z80_alu_sequencer
module tb_z80_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [7:0] op_data = 8'h00;
    logic       op_ready;
    logic [3:0] alu_select;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] acc;
    logic       zero;
    logic       retire;
    logic       illegal;

    int vectors = 0;
    int miscompares = 0;
    int retire_cnt = 0;
    int illegal_cnt = 0;

    logic [7:0] m_reg [8];
    logic       m_zero;

    z80_alu_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_valid   (op_valid),
        .op_data    (op_data),
        .op_ready   (op_ready),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .acc        (acc),
        .zero       (zero),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // External ALU.
    always_comb begin
        case (alu_select)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            default: alu_result = 8'hA5;
        endcase
    end

    always @(posedge clk) begin
        if (retire)  retire_cnt  <= retire_cnt + 1;
        if (illegal) illegal_cnt <= illegal_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_zero = 1'b0;
    endtask

    function automatic logic [7:0] ref_alu(input logic [2:0] y, input logic [7:0] a,
                                           input logic [7:0] b);
        case (y)
            3'd0:    return 8'(a + b);
            3'd2:    return 8'(a - b);
            3'd4:    return a & b;
            3'd5:    return a ^ b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] ref_sel(input logic [2:0] y);
        case (y)
            3'd0:    return 4'd0;
            3'd2:    return 4'd1;
            3'd4:    return 4'd2;
            3'd5:    return 4'd4;
            default: return 4'd3;
        endcase
    endfunction

    // Present one byte and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        op_valid = 1'b1;
        op_data  = b;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("send_timeout", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Issue one instruction, advance the model from the instruction's meaning and check.
    task automatic run_op(input logic [7:0] op, input logic [7:0] imm, input int gap);
        logic [1:0] x;
        logic [2:0] y;
        logic [2:0] z;
        logic       ok_ooo, is_nop, is_ld, alu_r, alu_i, bad;
        logic [7:0] ea, eb, res;
        int         r0, i0;
        x = op[7:6];
        y = op[5:3];
        z = op[2:0];
        ok_ooo = (y == 0) || (y == 2) || (y == 4) || (y == 5) || (y == 6);
        is_nop = (op == 8'h00);
        is_ld  = (x == 0) && (z == 6) && (y != 6);
        alu_r  = (x == 2) && ok_ooo && (z != 6);
        alu_i  = (x == 3) && ok_ooo && (z == 6);
        bad    = !(is_nop || is_ld || alu_r || alu_i);
        r0 = retire_cnt;
        i0 = illegal_cnt;

        send(op);
        if (is_ld || alu_i) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("imm_wait_ready", {31'd0, op_ready}, 32'd1);
                chk("imm_wait_acc", {24'd0, acc}, {24'd0, m_reg[7]});
                @(posedge clk);
                #1;
            end
            send(imm);
        end

        if (alu_r || alu_i) begin
            ea  = m_reg[7];
            eb  = alu_i ? imm : m_reg[z];
            res = ref_alu(y, ea, eb);
            @(negedge clk);
            chk("exec_ready", {31'd0, op_ready}, 32'd0);
            chk("exec_retire", {31'd0, retire}, 32'd1);
            chk("exec_sel", {28'd0, alu_select}, {28'd0, ref_sel(y)});
            chk("exec_a", {24'd0, alu_a}, {24'd0, ea});
            chk("exec_b", {24'd0, alu_b}, {24'd0, eb});
            m_reg[7] = res;
            m_zero   = (res == 8'h00);
        end else begin
            if (is_ld) m_reg[y] = imm;
            @(negedge clk);
            chk("post_ready", {31'd0, op_ready}, 32'd1);
            chk("post_retire", {31'd0, retire}, {31'd0, is_nop || is_ld});
            chk("post_illegal", {31'd0, illegal}, {31'd0, bad});
        end
        @(posedge clk);
        #1;
        chk("acc", {24'd0, acc}, {24'd0, m_reg[7]});
        chk("zero", {31'd0, zero}, {31'd0, m_zero});
        chk("retire_count", retire_cnt - r0, bad ? 32'd0 : 32'd1);
        chk("illegal_count", illegal_cnt - i0, bad ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [7:0] op;
        logic [2:0] rr;
        logic [2:0] oo;
        int         r0;
        logic [2:0] ooo_tab [5];
        ooo_tab[0] = 3'd0; ooo_tab[1] = 3'd2; ooo_tab[2] = 3'd4;
        ooo_tab[3] = 3'd5; ooo_tab[4] = 3'd6;

        model_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_acc", {24'd0, acc}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_sel", {28'd0, alu_select}, 32'd0);
        chk("rst_a", {24'd0, alu_a}, 32'd0);
        chk("rst_b", {24'd0, alu_b}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("release_ready", {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1;

        // LD A,12; LD B,34; ADD A,B
        run_op(8'h3E, 8'h12, 0);
        run_op(8'h06, 8'h34, 0);
        run_op(8'h80, 8'h00, 0);
        chk("plan_add", {24'd0, acc}, 32'h46);

        // Immediate ALU group
        run_op(8'hD6, 8'h50, 0);
        chk("plan_sub", {24'd0, acc}, 32'hF6);
        run_op(8'hE6, 8'h0F, 0);
        chk("plan_and", {24'd0, acc}, 32'h06);
        run_op(8'hEE, 8'h06, 0);
        chk("plan_xor", {24'd0, acc}, 32'h00);
        chk("plan_xor_zero", {31'd0, zero}, 32'd1);
        run_op(8'hF6, 8'h81, 0);
        chk("plan_or", {24'd0, acc}, 32'h81);

        // Unsupported opcodes
        run_op(8'h88, 8'h00, 0);
        run_op(8'h86, 8'h00, 0);
        run_op(8'h9F, 8'h00, 0);
        chk("plan_illegal_acc", {24'd0, acc}, 32'h81);

        // ADD A,A twice uses pre-op A
        run_op(8'h87, 8'h00, 0);
        chk("plan_adda1", {24'd0, acc}, 32'h02);
        run_op(8'h87, 8'h00, 0);
        chk("plan_adda2", {24'd0, acc}, 32'h04);

        // Immediate held off for 5 cycles
        run_op(8'hC6, 8'h01, 5);
        chk("plan_backpressure", {24'd0, acc}, 32'h05);

        // Reset while waiting for the LD immediate
        r0 = retire_cnt;
        send(8'h3E);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("abort_ready", {31'd0, op_ready}, 32'd1);
        chk("abort_acc", {24'd0, acc}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_no_retire", retire_cnt - r0, 32'd0);
        run_op(8'h00, 8'h00, 0);

        // Randomized instruction stream
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                op = 8'($urandom_range(0, 255));
            end else begin
                rr = 3'($urandom_range(0, 7));
                if (rr == 3'd6) rr = 3'd7;
                oo = ooo_tab[$urandom_range(0, 4)];
                case ($urandom_range(0, 2))
                    0:       op = {2'b00, rr, 3'b110};
                    1:       op = {2'b10, oo, rr};
                    default: op = {2'b11, oo, 3'b110};
                endcase
            end
            run_op(op, 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
